// File: rtl/wisc_pkg.sv
// Shared fetch/decode types and constants for the WISC pipeline.
package wisc_pkg;

    localparam logic [15:0] NOP_INSTR = 16'h0000;
    localparam int          IFQ_DEPTH = 2;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch-to-decode handshake bundle; master is the fetch/decode side, slave is the queue.
interface if_id_queue_if;

    logic        in_valid;
    logic [15:0] in_pc;
    logic [15:0] in_instr;
    logic        in_ready;
    logic        flush;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] out_pc;
    logic [15:0] out_instr;
    logic [1:0]  count;

    modport master (
        output in_valid, in_pc, in_instr, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, count
    );

    modport slave (
        input  in_valid, in_pc, in_instr, flush, out_ready,
        output in_ready, out_valid, out_pc, out_instr, count
    );

endinterface

// File: rtl/if_id_queue.sv
// Two-entry IF/ID queue; 1-cycle latency, or 0 with IFQ_BYPASS_EN when empty.
// Backpressure: in_ready drops when full or flushing; entries wait until out_ready.
module if_id_queue
    import wisc_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    if_id_queue_if.slave q
);

    localparam logic [1:0] FULL_CNT = 2'(IFQ_DEPTH);

    fetch_entry_t mem [IFQ_DEPTH];
    fetch_entry_t head;
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   cnt;
    logic         empty;
    logic         head_vld;
    logic         store;
    logic         take;

    assign empty      = (cnt == 2'd0);
    assign q.in_ready = (cnt < FULL_CNT) && !q.flush;

`ifdef IFQ_BYPASS_EN
    logic byp;

    // An empty queue hands the incoming word straight to decode; if decode
    // takes it this cycle it never lands in storage.
    assign byp      = empty && q.in_valid && !q.flush;
    assign head_vld = (!empty || q.in_valid) && !q.flush;
    assign head     = empty ? fetch_entry_t'{pc: q.in_pc, instr: q.in_instr} : mem[rd_ptr];
    assign store    = q.in_valid && q.in_ready && !(byp && q.out_ready);
    assign take     = head_vld && q.out_ready && !empty;
`else
    assign head_vld = !empty && !q.flush;
    assign head     = mem[rd_ptr];
    assign store    = q.in_valid && q.in_ready;
    assign take     = head_vld && q.out_ready;
`endif

    assign q.out_valid = head_vld;
    assign q.out_pc    = head_vld ? head.pc    : 16'h0000;
    assign q.out_instr = head_vld ? head.instr : NOP_INSTR;
    assign q.count     = cnt;

    always_ff @(posedge clk) begin
        if (!rst || q.flush) begin
            cnt    <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (store) wr_ptr <= wr_ptr + 1'b1;
            if (take)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + {1'b0, store} - {1'b0, take};
        end
    end

    // Storage needs no reset; only count and pointers define validity.
    always_ff @(posedge clk) begin
        if (store) mem[wr_ptr] <= fetch_entry_t'{pc: q.in_pc, instr: q.in_instr};
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios plus randomized traffic vs a queue model.
module tb_if_id_queue;
    import wisc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    if_id_queue_if ifc();

    if_id_queue dut (
        .clk (clk),
        .rst (rst),
        .q   (ifc)
    );

    // {out_valid, out_pc, out_instr, in_ready, count}
    logic [35:0] got;
    assign got = {ifc.out_valid, ifc.out_pc, ifc.out_instr, ifc.in_ready, ifc.count};

    task automatic drive(input logic v, input logic [15:0] pc, input logic [15:0] ins,
                         input logic fl, input logic ordy);
        ifc.in_valid  = v;
        ifc.in_pc     = pc;
        ifc.in_instr  = ins;
        ifc.flush     = fl;
        ifc.out_ready = ordy;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        repeat (3) tick();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        n_tests++;
        if (got !== {1'b0, 16'h0000, 16'h0000, 1'b1, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", got, {1'b0, 16'h0000, 16'h0000, 1'b1, 2'd0});
        end
    endtask

    task automatic test_single_push;
        drive(1'b1, 16'h0002, 16'hA123, 1'b0, 1'b0);
`ifndef IFQ_BYPASS_EN
        n_tests++;
        if (ifc.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL no_comb_path: out_valid got %b want 0", ifc.out_valid);
        end
`endif
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        n_tests++;
        if (got !== {1'b1, 16'h0002, 16'hA123, 1'b1, 2'd1}) begin
            n_fail++;
            $display("FAIL single_push: got %h want %h", got, {1'b1, 16'h0002, 16'hA123, 1'b1, 2'd1});
        end
        drain();
    endtask

    task automatic test_fill_full;
        drive(1'b1, 16'h0010, 16'h1111, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h0012, 16'h2222, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h0014, 16'h3333, 1'b0, 1'b0);
        n_tests++;
        if (got !== {1'b1, 16'h0010, 16'h1111, 1'b0, 2'd2}) begin
            n_fail++;
            $display("FAIL full_state: got %h want %h", got, {1'b1, 16'h0010, 16'h1111, 1'b0, 2'd2});
        end
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        n_tests++;
        if (got !== {1'b1, 16'h0010, 16'h1111, 1'b0, 2'd2}) begin
            n_fail++;
            $display("FAIL full_no_overwrite: got %h want %h", got, {1'b1, 16'h0010, 16'h1111, 1'b0, 2'd2});
        end
        tick();
        n_tests++;
        if (got !== {1'b1, 16'h0012, 16'h2222, 1'b1, 2'd1}) begin
            n_fail++;
            $display("FAIL full_second_out: got %h want %h", got, {1'b1, 16'h0012, 16'h2222, 1'b1, 2'd1});
        end
        tick();
        n_tests++;
        if (got !== {1'b0, 16'h0000, NOP_INSTR, 1'b1, 2'd0}) begin
            n_fail++;
            $display("FAIL full_drained: got %h want %h", got, {1'b0, 16'h0000, NOP_INSTR, 1'b1, 2'd0});
        end
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp_instr;
        drive(1'b1, 16'h0100, 16'h000F, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'h0200 + 16'(i), 16'h0010 + 16'(i), 1'b0, 1'b1);
            exp_instr = (i == 0) ? 16'h000F : 16'h000F + 16'(i);
            n_tests++;
            if ({ifc.out_valid, ifc.out_instr, ifc.in_ready, ifc.count} !== {1'b1, exp_instr, 1'b1, 2'd1}) begin
                n_fail++;
                $display("FAIL b2b_%0d: got v=%b instr=%h rdy=%b cnt=%0d want v=1 instr=%h rdy=1 cnt=1",
                         i, ifc.out_valid, ifc.out_instr, ifc.in_ready, ifc.count, exp_instr);
            end
            tick();
        end
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        n_tests++;
        if (got !== {1'b1, 16'h0203, 16'h0013, 1'b1, 2'd1}) begin
            n_fail++;
            $display("FAIL b2b_tail: got %h want %h", got, {1'b1, 16'h0203, 16'h0013, 1'b1, 2'd1});
        end
        drain();
    endtask

    task automatic test_flush;
        drive(1'b1, 16'h0020, 16'h4444, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h0022, 16'h5555, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h0024, 16'h6666, 1'b1, 1'b0);
        n_tests++;
        if ({ifc.out_valid, ifc.out_pc, ifc.out_instr, ifc.in_ready} !== {1'b0, 16'h0000, NOP_INSTR, 1'b0}) begin
            n_fail++;
            $display("FAIL flush_same_cycle: got v=%b pc=%h instr=%h rdy=%b want v=0 pc=0000 instr=0000 rdy=0",
                     ifc.out_valid, ifc.out_pc, ifc.out_instr, ifc.in_ready);
        end
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        n_tests++;
        if (got !== {1'b0, 16'h0000, NOP_INSTR, 1'b1, 2'd0}) begin
            n_fail++;
            $display("FAIL flush_next: got %h want %h", got, {1'b0, 16'h0000, NOP_INSTR, 1'b1, 2'd0});
        end
        drive(1'b1, 16'h0030, 16'h7777, 1'b0, 1'b0);
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        n_tests++;
        if (got !== {1'b1, 16'h0030, 16'h7777, 1'b1, 2'd1}) begin
            n_fail++;
            $display("FAIL flush_recover: got %h want %h", got, {1'b1, 16'h0030, 16'h7777, 1'b1, 2'd1});
        end
        drain();
    endtask

    task automatic test_reset_mid;
        drive(1'b1, 16'h0040, 16'h8888, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h0042, 16'h9999, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        drive(1'b1, 16'h0044, 16'hAAAA, 1'b1, 1'b1);
        tick();
        rst = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        n_tests++;
        if (got !== {1'b0, 16'h0000, NOP_INSTR, 1'b1, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_mid: got %h want %h", got, {1'b0, 16'h0000, NOP_INSTR, 1'b1, 2'd0});
        end
    endtask

`ifdef IFQ_BYPASS_EN
    task automatic test_bypass;
        drive(1'b1, 16'h0050, 16'hBEEF, 1'b0, 1'b1);
        n_tests++;
        if ({ifc.out_valid, ifc.out_pc, ifc.out_instr} !== {1'b1, 16'h0050, 16'hBEEF}) begin
            n_fail++;
            $display("FAIL bypass_same: got v=%b pc=%h instr=%h want v=1 pc=0050 instr=beef",
                     ifc.out_valid, ifc.out_pc, ifc.out_instr);
        end
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        n_tests++;
        if (got !== {1'b0, 16'h0000, NOP_INSTR, 1'b1, 2'd0}) begin
            n_fail++;
            $display("FAIL bypass_consumed: got %h want %h", got, {1'b0, 16'h0000, NOP_INSTR, 1'b1, 2'd0});
        end
    endtask
`endif

    task automatic test_random;
        fetch_entry_t mq[$];
        fetch_entry_t e_hd;
        logic         v, fl, ordy, rs, e_vld, e_rdy, acc;
        logic [15:0]  pc, ins;
        logic [35:0]  exp_t;
        int           sz;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int c = 0; c < 500; c++) begin
            v    = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 11) == 0);
            ordy = ($urandom_range(0, 2) != 0);
            rs   = ($urandom_range(0, 49) != 0);
            pc   = 16'($urandom);
            ins  = 16'($urandom);
            sz   = mq.size();
            e_rdy = (sz < 2) && !fl;
`ifdef IFQ_BYPASS_EN
            e_vld = (sz > 0 || v) && !fl;
`else
            e_vld = (sz > 0) && !fl;
`endif
            if (!e_vld)      e_hd = '0;
            else if (sz > 0) e_hd = mq[0];
            else             e_hd = fetch_entry_t'{pc: pc, instr: ins};
            exp_t = {e_vld, e_hd.pc, e_hd.instr, e_rdy, 2'(sz)};
            rst = rs;
            drive(v, pc, ins, fl, ordy);
            n_tests++;
            if (got !== exp_t) begin
                n_fail++;
                $display("FAIL random_cycle_%0d: got %h want %h", c, got, exp_t);
            end
            if (!rs || fl) begin
                mq.delete();
            end else begin
                acc = v && e_rdy;
                if (e_vld && ordy) begin
                    if (sz > 0) void'(mq.pop_front());
                    else        acc = 1'b0;
                end
                if (acc) mq.push_back(fetch_entry_t'{pc: pc, instr: ins});
            end
            tick();
            rst = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_fill_full();
        test_back_to_back();
        test_flush();
        test_reset_mid();
`ifdef IFQ_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
